seq_div_16by8: RTL and testbench
================================

SEQ_DIV_16BY8 -- requirements
Module: seq_div_16by8

Interface
REQ-001 The block SHALL have parameter N, default 8, meaning the divisor, quotient and remainder width; the dividend width SHALL be 2N.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: request a division; sampled only in IDLE.
REQ-005 The block SHALL have port dividend, input, 2N bits: unsigned dividend, sampled with an accepted start.
REQ-006 The block SHALL have port divisor, input, N bits: unsigned divisor, sampled with an accepted start.
REQ-007 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-008 The block SHALL have port done, output, 1 bit: high for exactly one cycle while in DONE.
REQ-009 The block SHALL have ports quotient, output, N bits, and remainder, output, N bits: the result.
REQ-010 The block SHALL have ports div_by_zero, output, 1 bit, and overflow, output, 1 bit: error flags.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, CALC and DONE.
REQ-012 A start sampled high in IDLE SHALL be accepted, and the block SHALL latch dividend and divisor on that edge.
REQ-013 Start SHALL be ignored in CALC and DONE; if start is held high, it SHALL be accepted in the first IDLE cycle after DONE.
REQ-014 The block SHALL use restoring division with a partial remainder of N+1 bits, initialised to dividend[2N-1:N].
REQ-015 Each CALC cycle SHALL shift the next lower dividend bit (MSB first) into the partial remainder.
REQ-016 In each CALC cycle, the block SHALL subtract divisor when the partial remainder is >= divisor, and SHALL shift 1 into the quotient, otherwise 0.
REQ-017 CALC SHALL last exactly N cycles, counted by an internal counter.
REQ-018 After an accept at edge k, the block SHALL enter DONE at edge k+N, so done is high between edges k+N and k+N+1.
REQ-019 The block SHALL always go from DONE to IDLE after one cycle.
REQ-020 A normal result SHALL satisfy dividend = quotient*divisor + remainder and remainder < divisor.
REQ-021 quotient, remainder, div_by_zero and overflow SHALL be registered.
REQ-022 These outputs SHALL be valid from the DONE cycle and held until the next accepted start.
REQ-023 On an accepted start, the block SHALL clear both flags.

Reset
REQ-024 rst_n low SHALL immediately force IDLE, including mid-CALC, and any in-flight operation SHALL be discarded without a done pulse.
REQ-025 rst_n low SHALL immediately force busy, done, quotient, remainder, div_by_zero and overflow to 0.
REQ-026 After reset release, the first rising edge with start high in IDLE SHALL be accepted.

Configuration
REQ-027 With macro DIV_ERR_CHECK_EN defined, an accepted start with divisor==0 SHALL go straight IDLE->DONE at edge k, with done high between edges k and k+1.
REQ-028 In that divisor==0 case, the block SHALL set div_by_zero=1, quotient=all ones and remainder=dividend[N-1:0].
REQ-029 With DIV_ERR_CHECK_EN defined, an accepted start with divisor!=0 and dividend[2N-1:N] >= divisor SHALL likewise go straight to DONE.
REQ-030 In that overflow case, the block SHALL set overflow=1, quotient=all ones and remainder=0.
REQ-031 Without DIV_ERR_CHECK_EN, the block SHALL tie div_by_zero and overflow to 0, and every accepted start SHALL run N CALC cycles.
REQ-032 Without DIV_ERR_CHECK_EN, results for zero-divisor or overflowing inputs SHALL be deterministic but unspecified.

Verification (N=8)
REQ-033 Basic: start with 0x1234/0x56 -> done 8 cycles after accept, quotient=0x36, remainder=0x10, flags 0.
REQ-034 Max legal: 0xFEFF/0xFF -> quotient=0xFF, remainder=0xFE; 0x00FF/0x01 -> quotient=0xFF, remainder=0x00.
REQ-035 Errors (macro defined): 0x1234/0x00 -> done 1 cycle after accept, div_by_zero=1, quotient=0xFF, remainder=0x34.
REQ-036 Errors (macro defined): 0x0100/0x01 -> overflow=1, quotient=0xFF, remainder=0x00.
REQ-037 Busy-ignore: pulse start with new operands during CALC and during DONE -> result unchanged; with start held high, the next accept follows DONE by exactly one IDLE cycle.
REQ-038 Reset mid-op: assert rst_n low at CALC cycle 4 -> all outputs 0 at once; no done pulse; a new start after release gives a correct result.
REQ-039 Randomised: for 1000 random legal operand pairs, quotient and remainder SHALL match the reference model, with busy high for exactly 9 cycles per operation.

Source files
------------

// File: rtl/seq_div_16by8.sv
// Sequential restoring divider: 2N-bit dividend by N-bit divisor, one quotient bit per cycle.
// Define DIV_ERR_CHECK_EN to short-circuit divide-by-zero and quotient overflow straight to DONE with flags.
module seq_div_16by8 #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [2*N-1:0] dividend,
  input  logic [N-1:0]   divisor,
  output logic           busy,
  output logic           done,
  output logic [N-1:0]   quotient,
  output logic [N-1:0]   remainder,
  output logic           div_by_zero,
  output logic           overflow
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state;
  logic [N:0]    part_rem;
  logic [N-1:0]  low_bits;
  logic [N-1:0]  quo_work;
  logic [N-1:0]  div_reg;
  logic [CW-1:0] count;

  logic [N:0]    shifted;
  logic          ge;
  logic [N:0]    diff;
  logic          err_zero;
  logic          err_ovf;
  logic          accept;

  assign busy   = (state != IDLE);
  assign done   = (state == DONE);
  assign accept = (state == IDLE) && start;

  always_comb begin
    shifted = {part_rem[N-1:0], low_bits[N-1]};
    ge      = (shifted >= {1'b0, div_reg});
    diff    = shifted - {1'b0, div_reg};
  end

  always_comb begin
    err_zero = 1'b0;
    err_ovf  = 1'b0;
`ifdef DIV_ERR_CHECK_EN
    err_zero = (divisor == '0);
    err_ovf  = !err_zero && (dividend[2*N-1:N] >= divisor);
`endif
  end

  // Result registers only change on completion, so they hold across the next op's CALC phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      part_rem  <= '0;
      low_bits  <= '0;
      quo_work  <= '0;
      div_reg   <= '0;
      count     <= '0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            div_reg  <= divisor;
            part_rem <= {1'b0, dividend[2*N-1:N]};
            low_bits <= dividend[N-1:0];
            quo_work <= '0;
            count    <= '0;
            if (err_zero) begin
              quotient  <= '1;
              remainder <= dividend[N-1:0];
              state     <= DONE;
            end else if (err_ovf) begin
              quotient  <= '1;
              remainder <= '0;
              state     <= DONE;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          part_rem <= ge ? diff : shifted;
          low_bits <= {low_bits[N-2:0], 1'b0};
          quo_work <= {quo_work[N-2:0], ge};
          count    <= count + 1'b1;
          if (count == CW'(N - 1)) begin
            quotient  <= {quo_work[N-2:0], ge};
            remainder <= ge ? diff[N-1:0] : shifted[N-1:0];
            state     <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DIV_ERR_CHECK_EN
  logic dbz_q;
  logic ovf_q;

  // Every accepted start rewrites both flags, which clears them for a legal operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dbz_q <= 1'b0;
      ovf_q <= 1'b0;
    end else if (accept) begin
      dbz_q <= err_zero;
      ovf_q <= err_ovf;
    end
  end

  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;
`else
  assign div_by_zero = 1'b0;
  assign overflow    = 1'b0;
`endif

endmodule

// File: tb/tb_seq_div_16by8.sv
// Directed and random checks of seq_div_16by8 (N=8): latency, results, flags, busy/start handling, reset.
module tb_seq_div_16by8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [15:0] dividend = '0;
  logic [7:0]  divisor = '0;
  logic        busy;
  logic        done;
  logic [7:0]  quotient;
  logic [7:0]  remainder;
  logic        div_by_zero;
  logic        overflow;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  seq_div_16by8 #(.N(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero),
    .overflow   (overflow)
  );

  task automatic run_op(input logic [15:0] a, input logic [7:0] b, input logic [7:0] eq,
                        input logic [7:0] er, input logic edbz, input logic eovf,
                        input int elat, input bit chk_qr, input string name);
    int cyc;
    int busy_cnt;
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    busy_cnt = 0;
    if (elat > 0) begin
      vectors++;
      if ({div_by_zero, overflow} !== 2'b00) begin
        miscompares++;
        $display("[TB] FAIL %s flags_clear: got %b, want 00", name, {div_by_zero, overflow});
      end
    end
    while (done !== 1'b1 && cyc < 40) begin
      if (busy === 1'b1) busy_cnt++;
      @(negedge clk);
      cyc++;
    end
    vectors++;
    if (cyc !== elat) begin
      miscompares++;
      $display("[TB] FAIL %s latency: got %0d, want %0d", name, cyc, elat);
    end
    vectors++;
    if (busy_cnt !== elat || busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL %s busy_cycles: got %0d+%b, want %0d+1", name, busy_cnt, busy, elat);
    end
    if (chk_qr) begin
      vectors++;
      if (quotient !== eq || remainder !== er) begin
        miscompares++;
        $display("[TB] FAIL %s result: got q=%h r=%h, want q=%h r=%h", name, quotient, remainder, eq, er);
      end
    end
    vectors++;
    if (div_by_zero !== edbz || overflow !== eovf) begin
      miscompares++;
      $display("[TB] FAIL %s flags: got dbz=%b ovf=%b, want dbz=%b ovf=%b",
               name, div_by_zero, overflow, edbz, eovf);
    end
    @(negedge clk);
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL %s after_done: got done=%b busy=%b, want 0 0", name, done, busy);
    end
    if (chk_qr) begin
      vectors++;
      if (quotient !== eq || remainder !== er) begin
        miscompares++;
        $display("[TB] FAIL %s held: got q=%h r=%h, want q=%h r=%h", name, quotient, remainder, eq, er);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({busy, done, quotient, remainder, div_by_zero, overflow} !== 20'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: got busy=%b done=%b q=%h r=%h dbz=%b ovf=%b, want all 0",
               busy, done, quotient, remainder, div_by_zero, overflow);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    run_op(16'h1234, 8'h56, 8'h36, 8'h10, 1'b0, 1'b0, 8, 1'b1, "basic_1234_56");
    run_op(16'h0000, 8'h07, 8'h00, 8'h00, 1'b0, 1'b0, 8, 1'b1, "zero_dividend");
    run_op(16'h0064, 8'h0A, 8'h0A, 8'h00, 1'b0, 1'b0, 8, 1'b1, "100_by_10");
    run_op(16'h03E8, 8'h21, 8'h1E, 8'h0A, 1'b0, 1'b0, 8, 1'b1, "1000_by_33");
  endtask

  task automatic test_max_legal();
    run_op(16'hFEFF, 8'hFF, 8'hFF, 8'hFE, 1'b0, 1'b0, 8, 1'b1, "max_FEFF_FF");
    run_op(16'h00FF, 8'h01, 8'hFF, 8'h00, 1'b0, 1'b0, 8, 1'b1, "max_00FF_01");
    run_op(16'h7FFF, 8'h80, 8'hFF, 8'h7F, 1'b0, 1'b0, 8, 1'b1, "max_7FFF_80");
  endtask

  task automatic test_errors();
`ifdef DIV_ERR_CHECK_EN
    run_op(16'h1234, 8'h00, 8'hFF, 8'h34, 1'b1, 1'b0, 0, 1'b1, "div_by_zero");
    run_op(16'h1234, 8'h56, 8'h36, 8'h10, 1'b0, 1'b0, 8, 1'b1, "after_dbz");
    run_op(16'h0100, 8'h01, 8'hFF, 8'h00, 1'b0, 1'b1, 0, 1'b1, "overflow");
    run_op(16'h00FF, 8'h01, 8'hFF, 8'h00, 1'b0, 1'b0, 8, 1'b1, "after_ovf");
`else
    run_op(16'h1234, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 8, 1'b0, "zero_div_noerr");
    run_op(16'h0100, 8'h01, 8'h00, 8'h00, 1'b0, 1'b0, 8, 1'b0, "overflow_noerr");
`endif
  endtask

  task automatic test_busy_ignore();
    int cyc;
    @(negedge clk);
    start = 1'b1; dividend = 16'h1234; divisor = 8'h56;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1; dividend = 16'hFFFF; divisor = 8'h01;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    vectors++;
    if (done !== 1'b1 || quotient !== 8'h36 || remainder !== 8'h10) begin
      miscompares++;
      $display("[TB] FAIL ignore_in_calc: got done=%b q=%h r=%h, want 1 36 10", done, quotient, remainder);
    end
    start = 1'b1; dividend = 16'h0064; divisor = 8'h0A;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || quotient !== 8'h36) begin
      miscompares++;
      $display("[TB] FAIL idle_gap: got busy=%b done=%b q=%h, want 0 0 36", busy, done, quotient);
    end
    @(negedge clk);
    start = 1'b0;
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL held_start_accept: got busy=%b, want 1", busy);
    end
    cyc = 0;
    while (done !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    vectors++;
    if (cyc !== 8 || quotient !== 8'h0A || remainder !== 8'h00) begin
      miscompares++;
      $display("[TB] FAIL held_start_result: got lat=%0d q=%h r=%h, want 8 0a 00", cyc, quotient, remainder);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_op();
    bit seen_done;
    @(negedge clk);
    start = 1'b1; dividend = 16'h03E8; divisor = 8'h21;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({busy, done, quotient, remainder, div_by_zero, overflow} !== 20'h0) begin
      miscompares++;
      $display("[TB] FAIL midop_reset_outputs: got busy=%b done=%b q=%h r=%h dbz=%b ovf=%b, want all 0",
               busy, done, quotient, remainder, div_by_zero, overflow);
    end
    seen_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 2) rst_n = 1'b1;
      if (done !== 1'b0 || (i > 2 && busy !== 1'b0)) seen_done = 1'b1;
    end
    vectors++;
    if (seen_done) begin
      miscompares++;
      $display("[TB] FAIL midop_no_done: got stray done/busy after reset, want none");
    end
    run_op(16'h03E8, 8'h21, 8'h1E, 8'h0A, 1'b0, 1'b0, 8, 1'b1, "after_midop_reset");
  endtask

  task automatic test_random();
    logic [7:0]  b;
    logic [7:0]  hi;
    logic [7:0]  lo;
    logic [15:0] a;
    for (int i = 0; i < 1000; i++) begin
      b  = 8'($urandom_range(1, 255));
      hi = 8'($urandom_range(0, int'(b) - 1));
      lo = 8'($urandom_range(0, 255));
      a  = {hi, lo};
      run_op(a, b, 8'(a / {8'h00, b}), 8'(a % {8'h00, b}), 1'b0, 1'b0, 8, 1'b1, "random");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max_legal();
    test_errors();
    test_busy_ignore();
    test_reset_mid_op();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
